fft_mem_sequencer: RTL

FFT_MEM_SEQUENCER -- requirements
Module: fft_mem_sequencer

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_mem_sequencer_if.sv | 20 ++
 rtl/fft_addr_delay.sv | 21 ++
 rtl/fft_mem_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and address helpers for the FFT memory sequencer.
package fft_pkg;
    localparam int MAXW = 16;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} seq_state_t;
    function automatic logic [MAXW-1:0] bit_reverse(input logic [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] r;
        r = {<<{v}};
        return r >> (MAXW - w);
    endfunction
    function automatic logic [MAXW-1:0] insert_zero(input logic [MAXW-1:0] v, input int pos);
        logic [MAXW-1:0] lo_mask;
        lo_mask = (MAXW'(1) << pos) - MAXW'(1);
        return ((v & ~lo_mask) << 1) | (v & lo_mask);
    endfunction
endpackage

// File: rtl/fft_mem_sequencer_if.sv
// fft_mem_sequencer_if: address/strobe bus between the sequencer and the ping-pong FFT memory.
interface fft_mem_sequencer_if #(parameter int ADDR_WIDTH = 5);
    logic init;
    logic roW;
    logic rd_valid;
    logic wr_valid;
    logic [ADDR_WIDTH-1:0] addr_A_read;
    logic [ADDR_WIDTH-1:0] addr_B_read;
    logic [ADDR_WIDTH-1:0] addr_A_write;
    logic [ADDR_WIDTH-1:0] addr_B_write;
    logic [ADDR_WIDTH-2:0] tw_idx;
    modport master (
        output init, roW, rd_valid, wr_valid,
        output addr_A_read, addr_B_read, addr_A_write, addr_B_write, tw_idx
    );
    modport slave (
        input init, roW, rd_valid, wr_valid,
        input addr_A_read, addr_B_read, addr_A_write, addr_B_write, tw_idx
    );
endinterface

// File: rtl/fft_addr_delay.sv
// fft_addr_delay: fixed-latency shift pipeline carrying {valid, addr_A, addr_B} to the write side.
module fft_addr_delay #(
    parameter int BFY_LATENCY = 3,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [BFY_LATENCY];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BFY_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < BFY_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign q = pipe[BFY_LATENCY-1];
endmodule

// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer: load / stage / drain controller generating radix-2 in-place FFT memory addresses.
module fft_mem_sequencer
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int BFY_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(ADDR_WIDTH)-1:0] stage,
    fft_mem_sequencer_if.master           mem
);
    localparam int SW = $clog2(ADDR_WIDTH);
    localparam int JW = ADDR_WIDTH - 1;
    seq_state_t state, state_n;
    logic [ADDR_WIDTH-1:0] load_cnt, load_n;
    logic [JW-1:0] j, j_n, tw_mask;
    logic [2:0] dcnt, dcnt_n;
    logic [SW-1:0] stage_n;
    logic row, row_n, last_stage, load_wr, rd, pv;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b, pa, pb;
    logic [2*ADDR_WIDTH:0] pipe_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            load_cnt <= '0;
            j <= '0;
            dcnt <= '0;
            stage <= '0;
            row <= 1'b0;
        end else begin
            state <= state_n;
            load_cnt <= load_n;
            j <= j_n;
            dcnt <= dcnt_n;
            stage <= stage_n;
            row <= row_n;
        end
    end
    assign last_stage = stage == SW'(ADDR_WIDTH - 1);
    always_comb begin
        state_n = state;
        load_n = load_cnt;
        j_n = j;
        dcnt_n = dcnt;
        stage_n = stage;
        row_n = row;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_LOAD;
                load_n = '0;
                j_n = '0;
                dcnt_n = '0;
                stage_n = '0;
            end
            S_LOAD: if (in_valid) begin
                load_n = load_cnt + ADDR_WIDTH'(1);
                if (&load_cnt) begin
                    state_n = S_RUN;
                    stage_n = '0;
                    row_n = 1'b0;
                    j_n = '0;
                end
            end
            S_RUN: begin
                j_n = j + JW'(1);
                if (&j) begin
                    state_n = S_DRAIN;
                    dcnt_n = '0;
                end
            end
            // the stage only advances (and the bank flips) once the last write has left the pipeline
            S_DRAIN: begin
                dcnt_n = dcnt + 3'd1;
                if (dcnt == 3'(BFY_LATENCY - 1)) begin
                    state_n = last_stage ? S_DONE : S_RUN;
                    stage_n = last_stage ? stage : stage + SW'(1);
                    row_n = last_stage ? row : ~row;
                    j_n = '0;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    assign rd = state == S_RUN;
    assign load_wr = state == S_LOAD && in_valid;
    assign addr_a = ADDR_WIDTH'(insert_zero(MAXW'(j), int'(stage)));
    assign addr_b = addr_a | (ADDR_WIDTH'(1) << stage);
    assign tw_mask = (JW'(1) << stage) - JW'(1);
    assign pipe_d = rd ? {1'b1, addr_a, addr_b} : '0;
    fft_addr_delay #(.BFY_LATENCY(BFY_LATENCY), .WIDTH(2 * ADDR_WIDTH + 1)) u_delay (
        .clk(clk),
        .rst_n(rst_n),
        .d(pipe_d),
        .q({pv, pa, pb})
    );
    assign mem.rd_valid = rd;
    assign mem.addr_A_read = rd ? addr_a : '0;
    assign mem.addr_B_read = rd ? addr_b : '0;
    assign mem.tw_idx = rd ? (j & tw_mask) << (SW'(JW) - stage) : '0;
    assign mem.wr_valid = pv | load_wr;
    assign mem.addr_A_write = load_wr ? ADDR_WIDTH'(bit_reverse(MAXW'(load_cnt), ADDR_WIDTH)) : pa;
    assign mem.addr_B_write = pb;
    assign mem.init = state != S_LOAD;
    assign mem.roW = row;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
endmodule
